// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the round-robin fifo write arbiter.
// Optional stall counter is enabled with FIFO_ARB_STALL_CNT_EN.
package fifo_arb_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_HOLD  = 2'd1,
        ST_STALL = 2'd2
    } arb_state_t;

    localparam int STALL_CNT_W = 16;

    // Reference round-robin pick: first set bit at or after ptr, wrapping at n.
    // Returns -1 when no request is set.
    function automatic int rr_pick(input logic [31:0] req, input int ptr, input int n);
        int win;
        win = -1;
        for (int s = 0; s < 32; s++) begin
            if (s < n && win < 0 && req[(ptr + s) % n]) begin
                win = (ptr + s) % n;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin selector: rotate requests by ptr, find the
// lowest set bit, then map the offset back to an absolute requester index.
module rr_priority_pick #(
    parameter  int NUM_REQ = 4,
    localparam int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic               any,
    output logic [ID_W-1:0]    winner
);

    logic [2*NUM_REQ-1:0] doubled;
    logic [NUM_REQ-1:0]   rotated;
    logic [ID_W-1:0]      offset;
    logic [ID_W:0]        sum;

    always_comb begin
        doubled = {req, req} >> ptr;
        rotated = doubled[NUM_REQ-1:0];
        offset  = '0;
        // Scan downward so the lowest set bit is the one left in offset.
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rotated[i]) begin
                offset = ID_W'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, offset};
        if (sum >= (ID_W + 1)'(NUM_REQ)) begin
            sum = sum - (ID_W + 1)'(NUM_REQ);
        end
        winner = sum[ID_W-1:0];
    end

    assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one fifo write port, with a one-entry output stage.
// Define FIFO_ARB_STALL_CNT_EN to add the saturating stall-cycle counter o_stall_cnt.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int NUM_REQ   = 4,
    parameter  int SIZE_DATA = 8,
    localparam int ID_W      = $clog2(NUM_REQ)
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [NUM_REQ-1:0]           i_req,
    input  logic [NUM_REQ*SIZE_DATA-1:0] i_req_data,
    output logic [NUM_REQ-1:0]           o_ack,
    input  logic                         i_fifo_full,
    output logic                         o_fifo_wr_en,
    output logic [ID_W+SIZE_DATA-1:0]    o_fifo_data,
    output logic                         o_busy,
`ifdef FIFO_ARB_STALL_CNT_EN
    output logic [STALL_CNT_W-1:0]       o_stall_cnt,
`endif
    output arb_state_t                   o_state
);

    arb_state_t                  state_q, state_d;
    logic [ID_W-1:0]             ptr_q, ptr_d;
    logic [ID_W+SIZE_DATA-1:0]   stage_q, stage_d;
    logic [ID_W-1:0]             winner;
    logic                        any_req;
    logic                        can_load;
    logic                        capture;

    rr_priority_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (i_req),
        .ptr    (ptr_q),
        .any    (any_req),
        .winner (winner)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_EMPTY;
            ptr_q   <= '0;
            stage_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            stage_q <= stage_d;
        end
    end

    // Handshake: o_ack[k] high means requester k's word is taken at the next
    // rising edge; a requester holds i_req and its data stable until then.
    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        stage_d      = stage_q;
        o_ack        = '0;
        o_fifo_wr_en = (state_q != ST_EMPTY) && !i_fifo_full && !i_rst;
        can_load     = (state_q == ST_EMPTY) || o_fifo_wr_en;
        capture      = can_load && any_req && !i_rst;
        if (capture) begin
            o_ack[winner] = 1'b1;
            stage_d       = {winner, i_req_data[winner*SIZE_DATA +: SIZE_DATA]};
            ptr_d         = (winner == ID_W'(NUM_REQ - 1)) ? '0 : winner + ID_W'(1);
            state_d       = ST_HOLD;
        end else if (o_fifo_wr_en) begin
            state_d = ST_EMPTY;
        end else if (state_q != ST_EMPTY) begin
            // Word was refused by a full fifo and is carried into the next cycle.
            state_d = ST_STALL;
        end
    end

    assign o_busy      = (state_q != ST_EMPTY);
    assign o_fifo_data = stage_q;
    assign o_state     = state_q;

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stall_cnt_q <= '0;
        end else if (o_busy && i_fifo_full && (stall_cnt_q != '1)) begin
            stall_cnt_q <= stall_cnt_q + 1'b1;
        end
    end

    assign o_stall_cnt = stall_cnt_q;
`endif

endmodule
